// File: rtl/key_load_unit.sv
// Serial key loader for a logic-locked core: shifts the key in, checks even parity,
// and only then drives it onto keyinput. Optional fail lockout under KEY_LOAD_LOCKOUT_EN.
module key_load_unit #(
  parameter int               KEY_W       = 3,
  parameter logic [KEY_W-1:0] DEFAULT_KEY = {KEY_W{1'b0}},
  parameter int               MAX_FAIL    = 3
) (
  input  logic             CK,
  input  logic             RST,
  input  logic             start,
  input  logic             kbit,
  input  logic             kvalid,
  output logic             kready,
  output logic [KEY_W-1:0] keyinput,
  output logic             key_valid,
  output logic             key_err,
  output logic             busy,
  output logic             lockout
);

  localparam int             CW       = $clog2(KEY_W + 1);
  localparam logic [CW-1:0]  PAR_BEAT = CW'(KEY_W);

`ifdef KEY_LOAD_LOCKOUT_EN
  typedef enum logic [2:0] {IDLE, SHIFT, CHECK, LOADED, LOCKOUT} state_t;
  localparam int FW = $clog2(MAX_FAIL + 1);
  logic [FW-1:0] fail_cnt;
  logic          fail_limit;
  assign fail_limit = (fail_cnt + FW'(1)) == FW'(MAX_FAIL);
`else
  typedef enum logic [1:0] {IDLE, SHIFT, CHECK, LOADED} state_t;
`endif

  state_t           state, state_nxt;
  logic [KEY_W-1:0] shadow;
  logic             par_bit;
  logic [CW-1:0]    cnt;
  logic             beat;
  logic             parity_ok;

  assign beat      = kvalid && kready;
  assign parity_ok = ~(^shadow ^ par_bit);

  always_ff @(posedge CK) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, LOADED: if (start) state_nxt = SHIFT;
      SHIFT:        if (beat && cnt == PAR_BEAT) state_nxt = CHECK;
      CHECK: begin
        if (parity_ok) state_nxt = LOADED;
`ifdef KEY_LOAD_LOCKOUT_EN
        else if (fail_limit) state_nxt = LOCKOUT;
`endif
        else state_nxt = IDLE;
      end
`ifdef KEY_LOAD_LOCKOUT_EN
      LOCKOUT:      state_nxt = LOCKOUT;
`endif
      default:      state_nxt = IDLE;
    endcase
  end

  // The parity beat is parked in par_bit rather than advancing cnt, so cnt never wraps.
  always_ff @(posedge CK) begin
    if (RST) begin
      shadow    <= '0;
      par_bit   <= 1'b0;
      cnt       <= '0;
      keyinput  <= DEFAULT_KEY;
      key_valid <= 1'b0;
      key_err   <= 1'b0;
`ifdef KEY_LOAD_LOCKOUT_EN
      fail_cnt  <= '0;
`endif
    end else begin
      case (state)
        IDLE, LOADED: begin
          if (start) begin
            keyinput  <= DEFAULT_KEY;
            key_valid <= 1'b0;
            key_err   <= 1'b0;
            cnt       <= '0;
          end
        end
        SHIFT: begin
          if (beat) begin
            if (cnt == PAR_BEAT) begin
              par_bit <= kbit;
            end else begin
              for (int i = 0; i < KEY_W; i++) begin
                if (cnt == CW'(i)) shadow[i] <= kbit;
              end
              cnt <= cnt + CW'(1);
            end
          end
        end
        CHECK: begin
          if (parity_ok) begin
            keyinput  <= shadow;
            key_valid <= 1'b1;
`ifdef KEY_LOAD_LOCKOUT_EN
            fail_cnt  <= '0;
`endif
          end else begin
            key_err   <= 1'b1;
`ifdef KEY_LOAD_LOCKOUT_EN
            fail_cnt  <= fail_cnt + FW'(1);
`endif
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    kready  = (state == SHIFT);
    busy    = (state == SHIFT) || (state == CHECK);
`ifdef KEY_LOAD_LOCKOUT_EN
    lockout = (state == LOCKOUT);
`else
    lockout = 1'b0;
`endif
  end

endmodule

// File: tb/tb_key_load_unit.sv
// Self-checking bench for key_load_unit: directed scenarios plus randomized loads
// checked against a beat-level reference model.
module tb_key_load_unit;

  localparam int KW       = 3;
  localparam int MAX_FAIL = 3;

  logic          CK = 1'b0;
  logic          RST, start, kbit, kvalid;
  logic          kready, key_valid, key_err, busy, lockout;
  logic [KW-1:0] keyinput;

  int n_tests  = 0;
  int n_failed = 0;
`ifdef KEY_LOAD_LOCKOUT_EN
  int model_fails = 0;
`endif

  key_load_unit dut (
    .CK(CK), .RST(RST), .start(start), .kbit(kbit), .kvalid(kvalid),
    .kready(kready), .keyinput(keyinput), .key_valid(key_valid),
    .key_err(key_err), .busy(busy), .lockout(lockout)
  );

  always #5 CK = ~CK;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick;
    @(posedge CK);
    #1;
  endtask

  task automatic do_reset;
    RST = 1'b1; start = 1'b0; kvalid = 1'b0; kbit = 1'b0;
    tick;
    RST = 1'b0;
`ifdef KEY_LOAD_LOCKOUT_EN
    model_fails = 0;
`endif
  endtask

  // Model: beat k is key bit k for k<KW, beat KW is parity; pass means an even number of ones.
  function automatic logic model_pass(input logic [KW:0] beats);
    return ($countones(beats) % 2) == 0;
  endfunction

  function automatic logic [KW-1:0] model_key(input logic [KW:0] beats);
    int v = 0;
    for (int k = 0; k < KW; k++) if (beats[k]) v += (1 << k);
    return model_pass(beats) ? v[KW-1:0] : '0;
  endfunction

  // Drives one full load; stall idle cycles precede every beat after the first.
  task automatic run_load(input logic [KW:0] beats, input int stall, input logic poke,
                          output int kr, output logic [KW-1:0] key_start,
                          output logic valid_start, output logic [KW-1:0] key_check,
                          output logic busy_check, output logic to);
    int budget;
    kr = 0; to = 1'b0;
    start = 1'b1;
    tick;
    start = 1'b0;
    key_start = keyinput; valid_start = key_valid;
    for (int b = 0; b <= KW; b++) begin
      if (b > 0) begin
        for (int s = 0; s < stall; s++) begin
          kvalid = 1'b0; kbit = ~beats[b]; start = poke;
          if (kready === 1'b1) kr++;
          tick;
        end
      end
      start = 1'b0; kvalid = 1'b1; kbit = beats[b];
      budget = 20;
      while (kready !== 1'b1 && budget > 0) begin
        tick;
        budget--;
      end
      if (budget == 0) to = 1'b1;
      if (kready === 1'b1) kr++;
      tick;
    end
    kvalid = 1'b0; start = 1'b0;
    key_check = keyinput; busy_check = busy;
    tick;
  endtask

  task automatic test_reset;
    RST = 1'b1; start = 1'b1; kvalid = 1'b1; kbit = 1'b1;
    tick;
    n_tests++; if (keyinput !== 3'b000) begin n_failed++; $display("[TB] FAIL reset_keyinput: got %b expected 000", keyinput); end
    n_tests++; if (key_valid !== 1'b0) begin n_failed++; $display("[TB] FAIL reset_key_valid: got %b expected 0", key_valid); end
    n_tests++; if (key_err !== 1'b0) begin n_failed++; $display("[TB] FAIL reset_key_err: got %b expected 0", key_err); end
    n_tests++; if (kready !== 1'b0) begin n_failed++; $display("[TB] FAIL reset_kready: got %b expected 0", kready); end
    n_tests++; if (busy !== 1'b0) begin n_failed++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    n_tests++; if (lockout !== 1'b0) begin n_failed++; $display("[TB] FAIL reset_lockout: got %b expected 0", lockout); end
    RST = 1'b0; start = 1'b0; kvalid = 1'b0; kbit = 1'b0;
  endtask

  task automatic test_good_load;
    int kr; logic [KW-1:0] ks, kc; logic vs, bc, to;
    do_reset;
    run_load(4'b0110, 0, 1'b0, kr, ks, vs, kc, bc, to);
    n_tests++; if (to !== 1'b0) begin n_failed++; $display("[TB] FAIL good_timeout: got %b expected 0", to); end
    n_tests++; if (kr !== 4) begin n_failed++; $display("[TB] FAIL good_kready_cycles: got %0d expected 4", kr); end
    n_tests++; if (kc !== 3'b000) begin n_failed++; $display("[TB] FAIL good_key_in_check: got %b expected 000", kc); end
    n_tests++; if (bc !== 1'b1) begin n_failed++; $display("[TB] FAIL good_busy_in_check: got %b expected 1", bc); end
    n_tests++; if (keyinput !== 3'b110) begin n_failed++; $display("[TB] FAIL good_keyinput: got %b expected 110", keyinput); end
    n_tests++; if (key_valid !== 1'b1) begin n_failed++; $display("[TB] FAIL good_key_valid: got %b expected 1", key_valid); end
    n_tests++; if (key_err !== 1'b0) begin n_failed++; $display("[TB] FAIL good_key_err: got %b expected 0", key_err); end
    n_tests++; if (busy !== 1'b0 || kready !== 1'b0) begin n_failed++; $display("[TB] FAIL good_idle_after: got busy=%b kready=%b expected 0 0", busy, kready); end
    repeat (3) tick;
    n_tests++; if (keyinput !== 3'b110 || key_valid !== 1'b1) begin n_failed++; $display("[TB] FAIL good_hold: got %b/%b expected 110/1", keyinput, key_valid); end
  endtask

  task automatic test_bad_parity;
    int kr; logic [KW-1:0] ks, kc; logic vs, bc, to;
    do_reset;
    run_load(4'b0001, 0, 1'b0, kr, ks, vs, kc, bc, to);
    n_tests++; if (key_err !== 1'b1) begin n_failed++; $display("[TB] FAIL bad_key_err: got %b expected 1", key_err); end
    n_tests++; if (key_valid !== 1'b0) begin n_failed++; $display("[TB] FAIL bad_key_valid: got %b expected 0", key_valid); end
    n_tests++; if (keyinput !== 3'b000) begin n_failed++; $display("[TB] FAIL bad_keyinput: got %b expected 000", keyinput); end
    n_tests++; if (busy !== 1'b0 || kready !== 1'b0) begin n_failed++; $display("[TB] FAIL bad_idle: got busy=%b kready=%b expected 0 0", busy, kready); end
    start = 1'b1;
    tick;
    start = 1'b0;
    n_tests++; if (key_err !== 1'b0) begin n_failed++; $display("[TB] FAIL bad_err_cleared: got %b expected 0", key_err); end
    n_tests++; if (kready !== 1'b1) begin n_failed++; $display("[TB] FAIL bad_restart_kready: got %b expected 1", kready); end
    do_reset;
  endtask

  task automatic test_stalls;
    int kr; logic [KW-1:0] ks, kc; logic vs, bc, to;
    do_reset;
    run_load(4'b0110, 2, 1'b1, kr, ks, vs, kc, bc, to);
    n_tests++; if (to !== 1'b0) begin n_failed++; $display("[TB] FAIL stall_timeout: got %b expected 0", to); end
    n_tests++; if (kr !== 4 + 3 * 2) begin n_failed++; $display("[TB] FAIL stall_kready_cycles: got %0d expected %0d", kr, 4 + 3 * 2); end
    n_tests++; if (keyinput !== 3'b110) begin n_failed++; $display("[TB] FAIL stall_keyinput: got %b expected 110", keyinput); end
    n_tests++; if (key_valid !== 1'b1) begin n_failed++; $display("[TB] FAIL stall_key_valid: got %b expected 1", key_valid); end
  endtask

  task automatic test_rekey;
    int kr; logic [KW-1:0] ks, kc; logic vs, bc, to;
    do_reset;
    run_load(4'b0110, 0, 1'b0, kr, ks, vs, kc, bc, to);
    run_load(4'b0101, 1, 1'b0, kr, ks, vs, kc, bc, to);
    n_tests++; if (ks !== 3'b000) begin n_failed++; $display("[TB] FAIL rekey_withdraw_key: got %b expected 000", ks); end
    n_tests++; if (vs !== 1'b0) begin n_failed++; $display("[TB] FAIL rekey_withdraw_valid: got %b expected 0", vs); end
    n_tests++; if (keyinput !== 3'b101) begin n_failed++; $display("[TB] FAIL rekey_keyinput: got %b expected 101", keyinput); end
    n_tests++; if (key_valid !== 1'b1) begin n_failed++; $display("[TB] FAIL rekey_key_valid: got %b expected 1", key_valid); end
  endtask

  task automatic test_reset_mid;
    int kr; logic [KW-1:0] ks, kc; logic vs, bc, to;
    do_reset;
    run_load(4'b0101, 0, 1'b0, kr, ks, vs, kc, bc, to);
    start = 1'b1;
    tick;
    start = 1'b0; kvalid = 1'b1; kbit = 1'b1;
    tick;
    tick;
    RST = 1'b1;
    tick;
    n_tests++; if (kready !== 1'b0 || busy !== 1'b0) begin n_failed++; $display("[TB] FAIL midrst_handshake: got kready=%b busy=%b expected 0 0", kready, busy); end
    n_tests++; if (keyinput !== 3'b000 || key_valid !== 1'b0) begin n_failed++; $display("[TB] FAIL midrst_key: got %b/%b expected 000/0", keyinput, key_valid); end
    n_tests++; if (key_err !== 1'b0 || lockout !== 1'b0) begin n_failed++; $display("[TB] FAIL midrst_flags: got err=%b lock=%b expected 0 0", key_err, lockout); end
    RST = 1'b0; kvalid = 1'b0;
`ifdef KEY_LOAD_LOCKOUT_EN
    model_fails = 0;
`endif
    run_load(4'b0110, 0, 1'b0, kr, ks, vs, kc, bc, to);
    n_tests++; if (keyinput !== 3'b110 || key_valid !== 1'b1) begin n_failed++; $display("[TB] FAIL midrst_reload: got %b/%b expected 110/1", keyinput, key_valid); end
  endtask

  task automatic test_random;
    int kr; logic [KW-1:0] ks, kc; logic vs, bc, to;
    logic [KW:0] beats; logic pass; logic [KW-1:0] exp_key; logic exp_lock;
    do_reset;
    for (int it = 0; it < 24; it++) begin
      beats = KW'(0) + ($urandom_range(0, (1 << (KW + 1)) - 1));
      run_load(beats, $urandom_range(0, 2), 1'($urandom_range(0, 1)), kr, ks, vs, kc, bc, to);
      pass = model_pass(beats);
      exp_key = model_key(beats);
      exp_lock = 1'b0;
`ifdef KEY_LOAD_LOCKOUT_EN
      if (pass) model_fails = 0;
      else model_fails++;
      exp_lock = (model_fails == MAX_FAIL);
`endif
      n_tests++; if (keyinput !== exp_key) begin n_failed++; $display("[TB] FAIL rand_keyinput[%0d]: got %b expected %b", it, keyinput, exp_key); end
      n_tests++; if (key_valid !== pass) begin n_failed++; $display("[TB] FAIL rand_key_valid[%0d]: got %b expected %b", it, key_valid, pass); end
      n_tests++; if (key_err !== !pass) begin n_failed++; $display("[TB] FAIL rand_key_err[%0d]: got %b expected %b", it, key_err, !pass); end
      n_tests++; if (lockout !== exp_lock) begin n_failed++; $display("[TB] FAIL rand_lockout[%0d]: got %b expected %b", it, lockout, exp_lock); end
      n_tests++; if (to !== 1'b0 || busy !== 1'b0) begin n_failed++; $display("[TB] FAIL rand_flow[%0d]: got timeout=%b busy=%b expected 0 0", it, to, busy); end
      if (exp_lock || lockout === 1'b1 || to === 1'b1) do_reset;
    end
  endtask

`ifdef KEY_LOAD_LOCKOUT_EN
  task automatic test_lockout;
    int kr; logic [KW-1:0] ks, kc; logic vs, bc, to;
    do_reset;
    run_load(4'b0001, 0, 1'b0, kr, ks, vs, kc, bc, to);
    run_load(4'b0001, 0, 1'b0, kr, ks, vs, kc, bc, to);
    run_load(4'b0110, 0, 1'b0, kr, ks, vs, kc, bc, to);
    run_load(4'b0001, 0, 1'b0, kr, ks, vs, kc, bc, to);
    run_load(4'b0001, 0, 1'b0, kr, ks, vs, kc, bc, to);
    n_tests++; if (lockout !== 1'b0) begin n_failed++; $display("[TB] FAIL lock_pass_clears: got %b expected 0", lockout); end
    run_load(4'b1000, 0, 1'b0, kr, ks, vs, kc, bc, to);
    n_tests++; if (lockout !== 1'b1) begin n_failed++; $display("[TB] FAIL lock_asserted: got %b expected 1", lockout); end
    n_tests++; if (key_err !== 1'b1 || keyinput !== 3'b000) begin n_failed++; $display("[TB] FAIL lock_outputs: got err=%b key=%b expected 1 000", key_err, keyinput); end
    start = 1'b1;
    tick;
    tick;
    start = 1'b0;
    n_tests++; if (kready !== 1'b0 || busy !== 1'b0) begin n_failed++; $display("[TB] FAIL lock_ignores_start: got kready=%b busy=%b expected 0 0", kready, busy); end
    n_tests++; if (lockout !== 1'b1) begin n_failed++; $display("[TB] FAIL lock_sticky: got %b expected 1", lockout); end
    RST = 1'b1;
    tick;
    RST = 1'b0;
    model_fails = 0;
    n_tests++; if (lockout !== 1'b0 || key_err !== 1'b0) begin n_failed++; $display("[TB] FAIL lock_reset_clears: got lock=%b err=%b expected 0 0", lockout, key_err); end
  endtask
`endif

  initial begin
    RST = 1'b1; start = 1'b0; kbit = 1'b0; kvalid = 1'b0;
    tick;
    test_reset;
    test_good_load;
    test_bad_parity;
    test_stalls;
    test_rekey;
    test_reset_mid;
    test_random;
`ifdef KEY_LOAD_LOCKOUT_EN
    test_lockout;
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
    $finish;
  end

endmodule

// File: doc/key_load_unit.md
Name: key_load_unit

Overview:
- Producer side of the logic-locking key interface: drives the `keyinput` bus of an obfuscated core.
- Receives the key serially from the tamper-proof key store over a valid/ready handshake, into a shadow register, and checks parity.
- Only a verified key reaches `keyinput`. Otherwise the bus holds a known-wrong DEFAULT_KEY, so the core stays functionally locked.
- Sits between the key-store controller and the locked netlist's `keyinput` pins.

Parameters:
- KEY_W, 3, key width in bits; equals the width of the locked core's `keyinput`.
- DEFAULT_KEY, {KEY_W{1'b0}}, value driven on `keyinput` whenever no verified key is applied.
- MAX_FAIL, 3, number of failed loads before lockout (used only with KEY_LOAD_LOCKOUT_EN).

Ports:
- CK  input  1  clock, rising edge.
- RST  input  1  reset; synchronous, active-high.
- start  input  1  request a key load; single-cycle pulse or level.
- kbit  input  1  serial key/parity bit.
- kvalid  input  1  kbit valid.
- kready  output  1  unit accepts kbit this cycle.
- keyinput  output  KEY_W  key to the locked core.
- key_valid  output  1  keyinput holds a verified key.
- key_err  output  1  last load failed parity; sticky.
- busy  output  1  load in progress (SHIFT or CHECK).
- lockout  output  1  fail limit reached; tied 0 without the macro.

Behaviour:
- Reset (RST high at a CK edge):
  - state=IDLE; keyinput=DEFAULT_KEY.
  - key_valid=0, key_err=0, kready=0, busy=0, lockout=0.
  - Shadow register and bit counter cleared.
  - Reset wins over every other event in the same cycle, including mid-SHIFT and mid-CHECK.
- States: IDLE, SHIFT, CHECK, LOADED, LOCKOUT (LOCKOUT exists only with the macro).
- Transitions on start:
  - IDLE or LOADED, start=1 → SHIFT at the next edge.
  - On that same edge: keyinput=DEFAULT_KEY, key_valid=0, key_err=0, counter=0.
  - Re-keying from LOADED therefore withdraws the old key immediately.
- SHIFT:
  - kready=1 and busy=1; kready is 0 in every other state.
  - A beat is accepted on an edge where kvalid&kready=1. kvalid=0 cycles are stalls, with no timeout.
  - Beats 0..KEY_W-1 are key bits, LSB first; beat k is written to shadow[k]. Beat KEY_W is the parity bit.
  - The counter is ceil(log2(KEY_W+1)) bits wide. It increments per accepted beat and never wraps: the parity beat exits SHIFT.
  - start is ignored while in SHIFT or CHECK.
- Parity: pass when the XOR of the KEY_W shadow bits and the parity bit is 0 (even parity).
- Timing of the parity beat and CHECK:
  - Parity beat accepted at edge E → state=CHECK for one cycle.
  - At edge E+1:
    - Pass: keyinput=shadow, key_valid=1, state=LOADED.
    - Fail: keyinput stays DEFAULT_KEY, key_err=1, state=IDLE.
  - keyinput never shows a partial or unchecked key.
- LOADED: keyinput and key_valid are held until a new start or RST.
- busy=1 exactly in SHIFT and CHECK.

Optional Feature:
- Macro: KEY_LOAD_LOCKOUT_EN.
- Defined:
  - A fail counter of ceil(log2(MAX_FAIL+1)) bits increments on each parity failure.
  - When a failure makes the count equal MAX_FAIL, the state goes to LOCKOUT at that CHECK edge instead of IDLE.
  - In LOCKOUT: lockout=1, key_err=1, keyinput=DEFAULT_KEY, and start is ignored.
  - Only RST exits LOCKOUT.
  - A successful load clears the fail counter.
- Not defined: no fail counter, no LOCKOUT state, lockout tied 0, MAX_FAIL unused.

Test Plan (KEY_W=3, DEFAULT_KEY=000, MAX_FAIL=3):
- Good load: RST, start, beats 0,1,1 then parity 0 with kvalid held high → kready high for 4 cycles; keyinput=110 and key_valid=1 one edge after the parity beat; busy low afterwards.
- Bad parity: beats 1,0,0 then parity 0 → key_err=1, key_valid=0, keyinput stays 000, state returns to IDLE; the next start clears key_err.
- Stalls: same as good load with kvalid low for 2 cycles between every beat → identical result (keyinput=110); no beat is accepted while kvalid=0; start pulses during SHIFT have no effect.
- Re-key: from LOADED with key 110, start → keyinput=000 and key_valid=0 at the next edge; then load 101 with parity 0 → keyinput=101.
- Reset mid-operation: RST asserted after 2 beats → all outputs at reset values the next cycle; a fresh load then works normally.
- Lockout (macro defined): 3 consecutive bad-parity loads → lockout=1 after the third CHECK; a further start → no kready; RST clears lockout.
